avr_fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program memory in the ATmega328PB core. It drives the 14-bit word address into program memory and accepts the 16-bit word returned one cycle later. It buffers fetched words and assembles one- or two-word AVR instructions (LDS/STS/JMP/CALL). It presents each instruction to the decoder with a valid/ready handshake and supports PC redirect with flushing of the wrong-path fetch.

---
 rtl/avr_fetch_pkg.sv | 18 +
 rtl/avr_fetch_if.sv | 25 ++
 rtl/avr_fetch_fifo.sv | 56 +++++
 rtl/avr_fetch_unit.sv | 74 +++++++
 tb/tb_avr_fetch_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/avr_fetch_pkg.sv
// rtl/avr_fetch_pkg.sv - shared constants and two-word opcode detection for the AVR fetch unit
package avr_fetch_pkg;

  localparam int PC_W   = 14;
  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] LDS_STS_MASK   = 16'hFC0F;
  localparam logic [WORD_W-1:0] LDS_STS_MATCH  = 16'h9000;
  localparam logic [WORD_W-1:0] JMP_CALL_MASK  = 16'hFE0C;
  localparam logic [WORD_W-1:0] JMP_CALL_MATCH = 16'h940C;

  // LDS/STS and JMP/CALL carry a second operand word
  function automatic logic is_two_word(input logic [WORD_W-1:0] word);
    return ((word & LDS_STS_MASK) == LDS_STS_MATCH) ||
           ((word & JMP_CALL_MASK) == JMP_CALL_MATCH);
  endfunction

endpackage

// File: rtl/avr_fetch_if.sv
// rtl/avr_fetch_if.sv - program-memory, decoder and redirect signals of the fetch unit
interface avr_fetch_if #(
  parameter int PC_W = avr_fetch_pkg::PC_W
);
  logic [PC_W-1:0]                 pm_addr;
  logic                            pm_en;
  logic [avr_fetch_pkg::WORD_W-1:0] pm_dout;
  logic                            instr_valid;
  logic                            instr_ready;
  logic [31:0]                     instr;
  logic [PC_W-1:0]                 instr_pc;
  logic                            instr_two_word;
  logic                            redirect_valid;
  logic [PC_W-1:0]                 redirect_pc;

  modport master (
    output pm_addr, pm_en, instr_valid, instr, instr_pc, instr_two_word,
    input  pm_dout, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  pm_addr, pm_en, instr_valid, instr, instr_pc, instr_two_word,
    output pm_dout, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/avr_fetch_fifo.sv
// rtl/avr_fetch_fifo.sv - word+address buffer with single push, pop of 0/1/2 entries and flush
module avr_fetch_fifo import avr_fetch_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = WORD_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [1:0]        pop_n,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] next_data
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  assign head_data = data_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign next_data = data_q[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && count == CNT_W'(DEPTH)));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  // Storage needs no reset: consumers qualify it with count
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_q[wr_ptr] <= push_data;
      addr_q[wr_ptr] <= push_addr;
    end
  end

endmodule

// File: rtl/avr_fetch_unit.sv
// rtl/avr_fetch_unit.sv - AVR instruction fetch: credit-based issue, two-word assembly, redirect flush
module avr_fetch_unit #(
  parameter int PC_W            = avr_fetch_pkg::PC_W,
  parameter int WORD_FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  avr_fetch_if.master   bus
);

  localparam int CNT_W  = $clog2(WORD_FIFO_DEPTH) + 1;
  localparam int WORD_W = avr_fetch_pkg::WORD_W;

  logic [PC_W-1:0]   fpc;
  logic [PC_W-1:0]   pend_addr;
  logic              inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W-1:0] head_data;
  logic [WORD_W-1:0] next_data;
  logic [PC_W-1:0]   head_addr;
  logic              head_two;
  logic              push;
  logic              valid;
  logic [1:0]        pop_n;

  // Counting the in-flight word as used space means a returning word always fits
  assign bus.pm_en   = !rst && (((fifo_count + CNT_W'(inflight)) < CNT_W'(WORD_FIFO_DEPTH)) ||
                                bus.redirect_valid);
  assign bus.pm_addr = bus.redirect_valid ? bus.redirect_pc : fpc;

  assign push     = inflight && !bus.redirect_valid;
  assign head_two = avr_fetch_pkg::is_two_word(head_data);
  assign valid    = !bus.redirect_valid && (fifo_count != '0) &&
                    (!head_two || fifo_count >= CNT_W'(2));
  assign pop_n    = (valid && bus.instr_ready) ? (head_two ? 2'd2 : 2'd1) : 2'd0;

  assign bus.instr_valid    = valid;
  assign bus.instr          = valid ? {(head_two ? next_data : 16'h0000), head_data} : 32'h0;
  assign bus.instr_pc       = valid ? head_addr : '0;
  assign bus.instr_two_word = valid && head_two;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc       <= '0;
      pend_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= bus.pm_en;
      if (bus.pm_en) begin
        fpc       <= bus.pm_addr + PC_W'(1);
        pend_addr <= bus.pm_addr;
      end
    end
  end

  avr_fetch_fifo #(
    .DEPTH  (WORD_FIFO_DEPTH),
    .ADDR_W (PC_W),
    .DATA_W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (bus.pm_dout),
    .push_addr (pend_addr),
    .pop_n     (pop_n),
    .count     (fifo_count),
    .head_data (head_data),
    .head_addr (head_addr),
    .next_data (next_data)
  );

endmodule

// File: tb/tb_avr_fetch_unit.sv
// tb/tb_avr_fetch_unit.sv - directed self-checking bench for avr_fetch_unit
module tb_avr_fetch_unit;

  localparam int PC_W = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avr_fetch_if #(.PC_W(PC_W)) bus ();

  avr_fetch_unit #(.PC_W(PC_W), .WORD_FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:(1<<PC_W)-1];

  // Single-cycle program memory
  always @(posedge clk) bus.pm_dout <= bus.pm_en ? mem[bus.pm_addr] : 16'hBAD0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_instr(input string tag, input logic v, input logic [31:0] ins,
                           input logic [PC_W-1:0] pc, input logic two);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(v));
    chk({tag, ".instr"}, bus.instr, ins);
    chk({tag, ".pc"}, 32'(bus.instr_pc), 32'(pc));
    chk({tag, ".two"}, 32'(bus.instr_two_word), 32'(two));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0]     t1_instr [9] = '{32'h0, 32'h0, 32'hE221, 32'hE232, 32'hE243,
                                    32'hE254, 32'h0, 32'h0800_9320, 32'h1006};
  logic [PC_W-1:0] t1_pc    [9] = '{14'd0, 14'd0, 14'd0, 14'd1, 14'd2, 14'd3, 14'd0, 14'd4, 14'd6};
  logic            t1_valid [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = 16'h1000 + i[15:0];
    mem[0]      = 16'hE221;
    mem[1]      = 16'hE232;
    mem[2]      = 16'hE243;
    mem[3]      = 16'hE254;
    mem[4]      = 16'h9320;
    mem[5]      = 16'h0800;
    mem[14'h090] = 16'h932F;
    mem[14'h3FFF] = 16'h940E;

    rst = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.pm_en", 32'(bus.pm_en), 32'd0);
    chk("rst.pm_addr", 32'(bus.pm_addr), 32'd0);
    chk_instr("rst", 1'b0, 32'h0, '0, 1'b0);

    // Startup, sequential stream, and the STS at word 4
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("run%0d.pm_en", c), 32'(bus.pm_en), 32'd1);
      chk($sformatf("run%0d.pm_addr", c), 32'(bus.pm_addr), 32'(c));
      chk_instr($sformatf("run%0d", c), t1_valid[c], t1_instr[c], t1_pc[c], c == 7);
      next_cycle();
    end

    // Back-pressure: issue stops once buffer plus in-flight reaches four
    for (int k = 0; k < 10; k++) begin
      bus.instr_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("hold%0d.pm_en", k), 32'(bus.pm_en), 32'(k < 2));
      chk_instr($sformatf("hold%0d", k), 1'b1, 32'h1007, 14'd7, 1'b0);
      next_cycle();
    end
    for (int k = 0; k < 6; k++) begin
      bus.instr_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("resume%0d.pm_en", k), 32'(bus.pm_en), 32'(k != 0));
      chk_instr($sformatf("resume%0d", k), 1'b1, 32'h1007 + 32'(k), 14'(7 + k), 1'b0);
      next_cycle();
    end

    // Redirect with a fetch in flight
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 14'h090;
    @(negedge clk);
    chk("redir.pm_en", 32'(bus.pm_en), 32'd1);
    chk("redir.pm_addr", 32'(bus.pm_addr), 32'h090);
    chk("redir.valid", 32'(bus.instr_valid), 32'd0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir1.pm_addr", 32'(bus.pm_addr), 32'h091);
    chk("redir1.valid", 32'(bus.instr_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk_instr("redir2", 1'b1, 32'h0000_932F, 14'h090, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_instr("redir3", 1'b1, 32'h0000_1091, 14'h091, 1'b0);
    next_cycle();

    // Two-word CALL straddling the address wrap
    mem[0] = 16'h0090;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 14'h3FFF;
    @(negedge clk);
    chk("wrap.pm_addr", 32'(bus.pm_addr), 32'h3FFF);
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap1.pm_addr", 32'(bus.pm_addr), 32'h0);
    chk("wrap1.valid", 32'(bus.instr_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("wrap2.valid", 32'(bus.instr_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk_instr("wrap3", 1'b1, 32'h0090_940E, 14'h3FFF, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_instr("wrap4", 1'b1, 32'h0000_E232, 14'd1, 1'b0);
    next_cycle();

    // Reset while the STS at word 4 is only half assembled
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 14'd4;
    next_cycle();
    bus.redirect_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("half.valid", 32'(bus.instr_valid), 32'd0);
    chk("half.pm_addr", 32'(bus.pm_addr), 32'd6);
    rst = 1'b1;
    #1;
    chk("arst.pm_en", 32'(bus.pm_en), 32'd0);
    chk("arst.pm_addr", 32'(bus.pm_addr), 32'd0);
    chk_instr("arst", 1'b0, 32'h0, '0, 1'b0);
    @(posedge clk);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rerun%0d.pm_addr", c), 32'(bus.pm_addr), 32'(c));
      chk_instr($sformatf("rerun%0d", c), c == 2, (c == 2) ? 32'h0090 : 32'h0, '0, 1'b0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
